// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/empty thresholds,
// sticky overflow/underflow flags and synchronous flush. Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clk,
    input  logic              rst_n,
    input  logic              Clr_i,
    input  logic              Wen_i,
    input  logic [DATA_W-1:0] Wdata_i,
    input  logic              Ren_i,
    output logic [DATA_W-1:0] Rdata_o,
    output logic              Rvalid_o,
    output logic              Wfull_o,
    output logic              Rempty_o,
    output logic              Afull_o,
    output logic              Aempty_o,
    output logic [ADDR_W:0]   Count_o,
    output logic              Ovf_o,
    output logic              Udf_o
);

    localparam logic [ADDR_W:0] AF_C    = AF_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_C    = AE_LVL[ADDR_W:0];
    localparam logic [ADDR_W:0] PTR_INC = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wptr;
    logic [ADDR_W:0]   r_rptr;
    logic [ADDR_W:0]   r_count;
    logic              r_full;
    logic              r_empty;
    logic              r_afull;
    logic              r_aempty;
    logic              r_ovf;
    logic              r_udf;

    logic              w_wr;
    logic              w_rd;
    logic [ADDR_W:0]   w_wptr_nxt;
    logic [ADDR_W:0]   w_rptr_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;
    logic              w_full_nxt;
    logic              w_empty_nxt;

    // A full FIFO drops the write; an empty one ignores the read.
    assign w_wr = Wen_i & ~r_full;
    assign w_rd = Ren_i & ~r_empty;

    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        w_cnt_nxt  = r_count;
        if (w_wr) w_wptr_nxt = r_wptr + PTR_INC;
        if (w_rd) w_rptr_nxt = r_rptr + PTR_INC;
        if (w_wr && !w_rd)      w_cnt_nxt = r_count + PTR_INC;
        else if (!w_wr && w_rd) w_cnt_nxt = r_count - PTR_INC;
    end

    assign w_full_nxt  = (w_wptr_nxt[ADDR_W] != w_rptr_nxt[ADDR_W]) &&
                         (w_wptr_nxt[ADDR_W-1:0] == w_rptr_nxt[ADDR_W-1:0]);
    assign w_empty_nxt = (w_wptr_nxt == w_rptr_nxt);

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else if (Clr_i) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wptr   <= w_wptr_nxt;
            r_rptr   <= w_rptr_nxt;
            r_count  <= w_cnt_nxt;
            r_full   <= w_full_nxt;
            r_empty  <= w_empty_nxt;
            r_afull  <= (w_cnt_nxt >= AF_C);
            r_aempty <= (w_cnt_nxt <= AE_C);
            r_ovf    <= r_ovf | (Wen_i & r_full);
            r_udf    <= r_udf | (Ren_i & r_empty);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge Clk) begin
        if (w_wr && !Clr_i) r_mem[r_wptr[ADDR_W-1:0]] <= Wdata_i;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign Rdata_o  = r_mem[r_rptr[ADDR_W-1:0]];
    assign Rvalid_o = ~r_empty;
`else
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
        end else if (Clr_i) begin
            r_rvalid <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) r_rdata <= r_mem[r_rptr[ADDR_W-1:0]];
        end
    end

    assign Rdata_o  = r_rdata;
    assign Rvalid_o = r_rvalid;
`endif

    assign Wfull_o  = r_full;
    assign Rempty_o = r_empty;
    assign Afull_o  = r_afull;
    assign Aempty_o = r_aempty;
    assign Count_o  = r_count;
    assign Ovf_o    = r_ovf;
    assign Udf_o    = r_udf;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF_LVL=14, AE_LVL=2).
module tb_sync_fifo_param;

    logic       Clk = 1'b0;
    logic       rst_n;
    logic       Clr_i, Wen_i, Ren_i;
    logic [7:0] Wdata_i;
    logic [7:0] Rdata_o;
    logic       Rvalid_o, Wfull_o, Rempty_o, Afull_o, Aempty_o, Ovf_o, Udf_o;
    logic [4:0] Count_o;

    int n_pass = 0;
    int n_tot  = 0;

    sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AF_LVL(14), .AE_LVL(2)) dut (
        .Clk(Clk), .rst_n(rst_n), .Clr_i(Clr_i), .Wen_i(Wen_i), .Wdata_i(Wdata_i),
        .Ren_i(Ren_i), .Rdata_o(Rdata_o), .Rvalid_o(Rvalid_o), .Wfull_o(Wfull_o),
        .Rempty_o(Rempty_o), .Afull_o(Afull_o), .Aempty_o(Aempty_o), .Count_o(Count_o),
        .Ovf_o(Ovf_o), .Udf_o(Udf_o)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       clr, wen, ren;
        logic [7:0] wdata;
        logic [4:0] cnt;
        logic       full, empty, afull, aempty, ovf, udf, rvalid;
        logic [7:0] rdata;
    } vec_t;

    function automatic vec_t mk(input logic clr, wen, ren, input logic [7:0] d,
                                input logic [4:0] cnt, input logic full, empty, afull, aempty,
                                ovf, udf, rv, input logic [7:0] rd);
        vec_t v;
        v.clr = clr; v.wen = wen; v.ren = ren; v.wdata = d; v.cnt = cnt;
        v.full = full; v.empty = empty; v.afull = afull; v.aempty = aempty;
        v.ovf = ovf; v.udf = udf; v.rvalid = rv; v.rdata = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step(input logic clr, wen, ren, input logic [7:0] d);
        Clr_i = clr; Wen_i = wen; Ren_i = ren; Wdata_i = d;
        @(posedge Clk); #1;
        Clr_i = 1'b0; Wen_i = 1'b0; Ren_i = 1'b0;
    endtask

    // Read (optionally with a write) and check the popped word in the mode-appropriate place.
    task automatic xfer(input string nm, input logic wen, input logic [7:0] d, input logic [7:0] exp);
`ifdef SYNC_FIFO_FWFT_EN
        chk({nm, "_rvalid"}, Rvalid_o, 1);
        chk({nm, "_rdata"}, Rdata_o, exp);
        step(1'b0, wen, 1'b1, d);
`else
        step(1'b0, wen, 1'b1, d);
        chk({nm, "_rvalid"}, Rvalid_o, 1);
        chk({nm, "_rdata"}, Rdata_o, exp);
`endif
    endtask

    vec_t vt[13];
    logic [7:0] q[$];

    initial begin
        rst_n = 1'b0; Clr_i = 1'b0; Wen_i = 1'b0; Ren_i = 1'b0; Wdata_i = '0;
        repeat (3) @(posedge Clk);
        #1 rst_n = 1'b1;

        // Reset state and asynchronous reset mid-stream
        chk("rst_count", Count_o, 0);
        chk("rst_empty", Rempty_o, 1);
        chk("rst_aempty", Aempty_o, 1);
        chk("rst_full", Wfull_o, 0);
        chk("rst_rvalid", Rvalid_o, 0);
        for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
        chk("t1_count5", Count_o, 5);
        xfer("t1_pop", 1'b0, 8'h00, 8'h11);
        rst_n = 1'b0;
        #1;
        chk("t1_count", Count_o, 0);
        chk("t1_empty", Rempty_o, 1);
        chk("t1_aempty", Aempty_o, 1);
        chk("t1_full", Wfull_o, 0);
        chk("t1_afull", Afull_o, 0);
        chk("t1_rvalid", Rvalid_o, 0);
        chk("t1_ovf", Ovf_o, 0);
        chk("t1_udf", Udf_o, 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t1_rdata", Rdata_o, 0);
`endif
        @(posedge Clk); #1 rst_n = 1'b1;

        // Table: clr wen ren wdata | cnt full empty afull aempty ovf udf rvalid rdata
        vt[0]  = mk(0,1,0,8'hA1, 1,0,0,0,1,0,0,0,8'h00);
        vt[1]  = mk(0,1,0,8'hA2, 2,0,0,0,1,0,0,0,8'h00);
        vt[2]  = mk(0,1,0,8'hA3, 3,0,0,0,0,0,0,0,8'h00);
        vt[3]  = mk(0,0,1,8'h00, 2,0,0,0,1,0,0,1,8'hA1);
        vt[4]  = mk(0,1,1,8'hA4, 2,0,0,0,1,0,0,1,8'hA2);
        vt[5]  = mk(0,0,0,8'h00, 2,0,0,0,1,0,0,0,8'hA2);
        vt[6]  = mk(0,0,1,8'h00, 1,0,0,0,1,0,0,1,8'hA3);
        vt[7]  = mk(0,0,1,8'h00, 0,0,1,0,1,0,0,1,8'hA4);
        vt[8]  = mk(0,0,1,8'h00, 0,0,1,0,1,0,1,0,8'hA4);
        vt[9]  = mk(0,1,1,8'hA5, 1,0,0,0,1,0,1,0,8'hA4);
        vt[10] = mk(1,1,0,8'hA6, 0,0,1,0,1,0,0,0,8'hA4);
        vt[11] = mk(0,0,1,8'h00, 0,0,1,0,1,0,1,0,8'hA4);
        vt[12] = mk(1,0,1,8'h00, 0,0,1,0,1,0,0,0,8'hA4);
        for (int i = 0; i < 13; i++) begin
            step(vt[i].clr, vt[i].wen, vt[i].ren, vt[i].wdata);
            chk($sformatf("v%0d_count", i), Count_o, vt[i].cnt);
            chk($sformatf("v%0d_full", i), Wfull_o, vt[i].full);
            chk($sformatf("v%0d_empty", i), Rempty_o, vt[i].empty);
            chk($sformatf("v%0d_afull", i), Afull_o, vt[i].afull);
            chk($sformatf("v%0d_aempty", i), Aempty_o, vt[i].aempty);
            chk($sformatf("v%0d_ovf", i), Ovf_o, vt[i].ovf);
            chk($sformatf("v%0d_udf", i), Udf_o, vt[i].udf);
`ifndef SYNC_FIFO_FWFT_EN
            chk($sformatf("v%0d_rvalid", i), Rvalid_o, vt[i].rvalid);
            chk($sformatf("v%0d_rdata", i), Rdata_o, vt[i].rdata);
`endif
        end

        // Fill to full, then overflow
        for (int i = 1; i <= 16; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'(i));
`ifdef SYNC_FIFO_FWFT_EN
            if (i == 1) chk("t2_fwft_first", Rdata_o, 1);
`endif
            chk($sformatf("t2_count%0d", i), Count_o, i);
            chk($sformatf("t2_afull%0d", i), Afull_o, (i >= 14) ? 1 : 0);
            chk($sformatf("t2_full%0d", i), Wfull_o, (i == 16) ? 1 : 0);
        end
        step(1'b0, 1'b1, 1'b0, 8'h11);
        chk("t2_ovf_count", Count_o, 16);
        chk("t2_ovf", Ovf_o, 1);

        // Drain in order, then underflow
        for (int i = 1; i <= 16; i++) xfer($sformatf("t3_rd%0d", i), 1'b0, 8'h00, 8'(i));
        chk("t3_empty", Rempty_o, 1);
        chk("t3_count", Count_o, 0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("t3_udf", Udf_o, 1);
        chk("t3_rvalid", Rvalid_o, 0);
        chk("t3_ovf_sticky", Ovf_o, 1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("t3_clr_ovf", Ovf_o, 0);
        chk("t3_clr_udf", Udf_o, 0);

        // Random gaps across pointer wrap, checked against a queue model
        begin
            int nwr = 0, nrd = 0, cyc = 0;
            logic w, r;
            logic [7:0] exp;
            while (nrd < 40 && cyc < 3000) begin
                w = (nwr < 40) && (q.size() < 16) && ($urandom_range(0, 2) != 0);
                r = (q.size() > 0) && ($urandom_range(0, 2) == 0);
                exp = (q.size() > 0) ? q[0] : 8'h00;
`ifdef SYNC_FIFO_FWFT_EN
                if (r) chk("t4_rdata", Rdata_o, exp);
`endif
                step(1'b0, w, r, 8'(8'h40 + nwr));
                if (r) begin void'(q.pop_front()); nrd++; end
                if (w) begin q.push_back(8'(8'h40 + nwr)); nwr++; end
`ifndef SYNC_FIFO_FWFT_EN
                chk("t4_rvalid", Rvalid_o, r);
                if (r) chk("t4_rdata", Rdata_o, exp);
`endif
                chk("t4_count", Count_o, q.size());
                cyc++;
            end
            chk("t4_done", nrd, 40);
        end

        // Simultaneous read/write at half, full and empty
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h80 + i));
        for (int k = 0; k < 10; k++) begin
            xfer($sformatf("t5_rw%0d", k), 1'b1, 8'(8'h88 + k), 8'(8'h80 + k));
            chk($sformatf("t5_cnt%0d", k), Count_o, 8);
        end
        for (int k = 10; k < 18; k++) xfer($sformatf("t5_dr%0d", k), 1'b0, 8'h00, 8'(8'h80 + k));
        chk("t5_drained", Rempty_o, 1);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 8'(8'hC0 + i));
        xfer("t5_full_rw", 1'b1, 8'hEE, 8'hC0);
        chk("t5_full_cnt", Count_o, 15);
        chk("t5_full_ovf", Ovf_o, 1);
        chk("t5_full_flag", Wfull_o, 0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h5A);
        chk("t5_empty_cnt", Count_o, 1);
        chk("t5_empty_udf", Udf_o, 1);
`ifdef SYNC_FIFO_FWFT_EN
        chk("t5_empty_rvalid", Rvalid_o, 1);
`else
        chk("t5_empty_rvalid", Rvalid_o, 0);
`endif
        xfer("t5_empty_pop", 1'b0, 8'h00, 8'h5A);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        // Flush beats a concurrent write
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
        for (int i = 0; i < 9; i++) xfer($sformatf("t6_rd%0d", i), 1'b0, 8'h00, 8'(8'h20 + i));
        chk("t6_cnt7", Count_o, 7);
        chk("t6_ovf1", Ovf_o, 1);
        step(1'b1, 1'b1, 1'b0, 8'h77);
        chk("t6_clr_cnt", Count_o, 0);
        chk("t6_clr_empty", Rempty_o, 1);
        chk("t6_clr_ovf", Ovf_o, 0);
        chk("t6_clr_rvalid", Rvalid_o, 0);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t6_no_write", Count_o, 0);
        step(1'b0, 1'b1, 1'b0, 8'h99);
        xfer("t6_after_clr", 1'b0, 8'h00, 8'h99);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
